// File: rtl/sdrc_wrbuf_pkg.sv
// Shared definitions for the SDRAM application write buffer.
//   wrbuf_state_e : burst-tracking FSM encoding (IDLE / ARMED / XFER)
//   DEF_AW, DEPTH : default FIFO address width and the matching word depth
package sdrc_wrbuf_pkg;

    localparam int unsigned DEF_AW = 4;
    localparam int unsigned DEPTH  = 2**DEF_AW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_XFER  = 2'd2
    } wrbuf_state_e;

endpackage

// File: rtl/sdrc_app_wrbuf_if.sv
// Bus bundle between the write master / bus-width converter and the write buffer.
//   Master-side inputs  : wr_valid, wr_data, wr_en_n, burst_len, flush, app_wr_next, app_last_wr
//   Buffer-side outputs : wr_ready, burst_ready, app_wr_data, app_wr_en_n, level,
//                         burst_done, underrun_err, len_err
//   modport slave  : the buffer's view
//   modport master : the environment's view (write master plus converter)
interface sdrc_app_wrbuf_if #(
    parameter int unsigned APP_DW = 32,
    parameter int unsigned APP_BW = 4,
    parameter int unsigned AW     = 4,
    parameter int unsigned BL_W   = 8
);
    logic              wr_valid;
    logic [APP_DW-1:0] wr_data;
    logic [APP_BW-1:0] wr_en_n;
    logic              wr_ready;
    logic [BL_W-1:0]   burst_len;
    logic              burst_ready;
    logic              flush;
    logic              app_wr_next;
    logic              app_last_wr;
    logic [APP_DW-1:0] app_wr_data;
    logic [APP_BW-1:0] app_wr_en_n;
    logic [AW:0]       level;
    logic              burst_done;
    logic              underrun_err;
    logic              len_err;

    modport slave (
        input  wr_valid, wr_data, wr_en_n, burst_len, flush, app_wr_next, app_last_wr,
        output wr_ready, burst_ready, app_wr_data, app_wr_en_n, level,
               burst_done, underrun_err, len_err
    );

    modport master (
        output wr_valid, wr_data, wr_en_n, burst_len, flush, app_wr_next, app_last_wr,
        input  wr_ready, burst_ready, app_wr_data, app_wr_en_n, level,
               burst_done, underrun_err, len_err
    );

endinterface

// File: rtl/sdrc_sync_fifo.sv
// Synchronous FIFO holding write words with their byte enables.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   flush_i          : clear pointers and level (wins over push/pop)
//   push_i, wdata_i, wen_n_i : write request (ignored when full)
//   pop_i            : advance the head (ignored when empty)
//   rdata_o, ren_n_o : head word; zero data / all-ones enables when empty
//   level_o          : words held; level_next_o is the value after this edge
//   full_o, empty_o  : status
module sdrc_sync_fifo
    import sdrc_wrbuf_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned BW = 4,
    parameter int unsigned AW = DEF_AW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [BW-1:0] wen_n_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic [BW-1:0] ren_n_o,
    output logic [AW:0]   level_o,
    output logic [AW:0]   level_next_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int unsigned FIFO_DEPTH = 2**AW;

    logic [DW+BW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wp_q;
    logic [AW-1:0]    rp_q;
    logic [AW:0]      level_q;
    logic [AW:0]      level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == (AW+1)'(FIFO_DEPTH));
    assign empty_o = (level_q == '0);
    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        level_d = level_q;
        if (flush_i) begin
            level_d = '0;
        end else if (push_ok && !pop_ok) begin
            level_d = level_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
        end else begin
            level_q <= level_d;
            if (flush_i) begin
                wp_q <= '0;
                rp_q <= '0;
            end else begin
                if (push_ok) wp_q <= wp_q + AW'(1);
                if (pop_ok)  rp_q <= rp_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wp_q] <= {wen_n_i, wdata_i};
    end

    assign {ren_n_o, rdata_o} = empty_o ? {{BW{1'b1}}, {DW{1'b0}}} : mem_q[rp_q];
    assign level_o      = level_q;
    assign level_next_o = level_d;

endmodule

// File: rtl/sdrc_app_wrbuf.sv
// Application-side write buffer in front of the SDRAM bus-width converter.
//   clk, reset : clock, synchronous active-high reset
//   bus        : sdrc_app_wrbuf_if.slave (write handshake, head word, burst status, errors)
// The FIFO stores words; this level tracks bursts (IDLE/ARMED/XFER), counts
// words per burst against burst_len and keeps the sticky error flags.
module sdrc_app_wrbuf
    import sdrc_wrbuf_pkg::*;
#(
    parameter int unsigned APP_DW = 32,
    parameter int unsigned APP_BW = 4,
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned BL_W   = 8
) (
    input logic             clk,
    input logic             reset,
    sdrc_app_wrbuf_if.slave bus
);
    wrbuf_state_e    state_q;
    logic [BL_W-1:0] cnt_q;
    logic            sat_q;
    logic            burst_done_q;
    logic            underrun_q;
    logic            len_err_q;

    logic            pop_req;
    logic            fifo_full;
    logic            fifo_empty;
    logic [AW:0]     level_w;
    logic [AW:0]     level_nx;
    logic [BL_W-1:0] cnt_inc;
    logic            sat_inc;
    logic            mismatch;

    // A last strobe without app_wr_next still consumes the final word.
    assign pop_req = bus.app_wr_next | bus.app_last_wr;

    sdrc_sync_fifo #(
        .DW (APP_DW),
        .BW (APP_BW),
        .AW (AW)
    ) u_fifo (
        .clk_i        (clk),
        .rst_i        (reset),
        .flush_i      (bus.flush),
        .push_i       (bus.wr_valid),
        .wdata_i      (bus.wr_data),
        .wen_n_i      (bus.wr_en_n),
        .pop_i        (pop_req),
        .rdata_o      (bus.app_wr_data),
        .ren_n_o      (bus.app_wr_en_n),
        .level_o      (level_w),
        .level_next_o (level_nx),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    // cnt_q is zero whenever ARMED, so the same increment covers the first word.
    // Once the counter has hit all-ones the burst can no longer match.
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + BL_W'(1);
    assign sat_inc  = sat_q | (cnt_q == '1);
    assign mismatch = sat_inc | (cnt_inc != bus.burst_len);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
            burst_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            burst_done_q <= 1'b0;
            if (bus.flush) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                sat_q   <= 1'b0;
            end else begin
                if (pop_req && fifo_empty) underrun_q <= 1'b1;
                unique case (state_q)
                    ST_IDLE: begin
                        if (level_w != '0) state_q <= ST_ARMED;
                    end
                    ST_ARMED, ST_XFER: begin
                        if (pop_req) begin
                            if (bus.app_last_wr) begin
                                burst_done_q <= 1'b1;
                                if (mismatch) len_err_q <= 1'b1;
                                cnt_q   <= '0;
                                sat_q   <= 1'b0;
                                state_q <= (level_nx != '0) ? ST_ARMED : ST_IDLE;
                            end else begin
                                cnt_q   <= cnt_inc;
                                sat_q   <= sat_inc;
                                state_q <= ST_XFER;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.wr_ready     = ~fifo_full;
    assign bus.level        = level_w;
    assign bus.burst_ready  = (state_q == ST_ARMED) && (bus.burst_len != '0) &&
                              (32'(level_w) >= 32'(bus.burst_len));
    assign bus.burst_done   = burst_done_q;
    assign bus.underrun_err = underrun_q;
    assign bus.len_err      = len_err_q;

endmodule

// File: tb/tb_sdrc_app_wrbuf.sv
// Testbench for sdrc_app_wrbuf: vector table, directed multi-cycle sequences,
// and a randomized burst phase checked against a queue-based model.
module tb_sdrc_app_wrbuf;
    import sdrc_wrbuf_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    sdrc_app_wrbuf_if #(.APP_DW(32), .APP_BW(4), .AW(4), .BL_W(8)) bus ();

    sdrc_app_wrbuf #(
        .APP_DW (32),
        .APP_BW (4),
        .AW     (4),
        .BL_W   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic [3:0]  we;
        logic [7:0]  bl;
        logic        nx;
        logic        ls;
        logic [4:0]  x_lvl;
        logic        x_rdy;
        logic [31:0] x_data;
        logic [3:0]  x_en;
        logic        x_bd;
        logic        x_le;
        logic        x_ur;
    } vec_t;

    function automatic vec_t mk(logic wv, logic [31:0] wd, logic [3:0] we, logic [7:0] bl,
                                logic nx, logic ls, logic [4:0] lvl, logic rdy,
                                logic [31:0] xd, logic [3:0] xe, logic bd, logic le, logic ur);
        vec_t v;
        v.wv = wv; v.wd = wd; v.we = we; v.bl = bl; v.nx = nx; v.ls = ls;
        v.x_lvl = lvl; v.x_rdy = rdy; v.x_data = xd; v.x_en = xe;
        v.x_bd = bd; v.x_le = le; v.x_ur = ur;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [31:0] wd, input logic [3:0] we,
                         input logic nx, input logic ls, input logic fl);
        bus.wr_valid    = wv;
        bus.wr_data     = wd;
        bus.wr_en_n     = we;
        bus.app_wr_next = nx;
        bus.app_last_wr = ls;
        bus.flush       = fl;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_level"},    64'(bus.level), 64'd0);
        chk({tag, "_wr_ready"}, 64'(bus.wr_ready), 64'd1);
        chk({tag, "_bready"},   64'(bus.burst_ready), 64'd0);
        chk({tag, "_bdone"},    64'(bus.burst_done), 64'd0);
        chk({tag, "_underrun"}, 64'(bus.underrun_err), 64'd0);
        chk({tag, "_len_err"},  64'(bus.len_err), 64'd0);
        chk({tag, "_data"},     64'(bus.app_wr_data), 64'd0);
        chk({tag, "_en_n"},     64'(bus.app_wr_en_n), 64'hF);
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 4'hF, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    vec_t        tv [21];
    logic [35:0] mq [$];
    logic [35:0] lst_w [16];

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        bus.burst_len = 8'd4;
        drive(1'b0, '0, 4'hF, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        check_reset_vals("reset");

        // Four-word burst, short burst, underrun, single-word burst via last only.
        tv[0]  = mk(1, 32'hA000_0000, 4'h0, 8'd4, 0, 0, 5'd1, 0, 32'hA000_0000, 4'h0, 0, 0, 0);
        tv[1]  = mk(1, 32'hA000_0001, 4'h0, 8'd4, 0, 0, 5'd2, 0, 32'hA000_0000, 4'h0, 0, 0, 0);
        tv[2]  = mk(1, 32'hA000_0002, 4'h0, 8'd4, 0, 0, 5'd3, 0, 32'hA000_0000, 4'h0, 0, 0, 0);
        tv[3]  = mk(1, 32'hA000_0003, 4'h0, 8'd4, 0, 0, 5'd4, 1, 32'hA000_0000, 4'h0, 0, 0, 0);
        tv[4]  = mk(0, 32'h0,         4'hF, 8'd4, 1, 0, 5'd3, 0, 32'hA000_0001, 4'h0, 0, 0, 0);
        tv[5]  = mk(0, 32'h0,         4'hF, 8'd4, 1, 0, 5'd2, 0, 32'hA000_0002, 4'h0, 0, 0, 0);
        tv[6]  = mk(0, 32'h0,         4'hF, 8'd4, 1, 0, 5'd1, 0, 32'hA000_0003, 4'h0, 0, 0, 0);
        tv[7]  = mk(0, 32'h0,         4'hF, 8'd4, 1, 1, 5'd0, 0, 32'h0,         4'hF, 1, 0, 0);
        tv[8]  = mk(0, 32'h0,         4'hF, 8'd4, 0, 0, 5'd0, 0, 32'h0,         4'hF, 0, 0, 0);
        tv[9]  = mk(1, 32'hB000_0000, 4'h3, 8'd4, 0, 0, 5'd1, 0, 32'hB000_0000, 4'h3, 0, 0, 0);
        tv[10] = mk(1, 32'hB000_0001, 4'hC, 8'd4, 0, 0, 5'd2, 0, 32'hB000_0000, 4'h3, 0, 0, 0);
        tv[11] = mk(1, 32'hB000_0002, 4'h0, 8'd4, 0, 0, 5'd3, 0, 32'hB000_0000, 4'h3, 0, 0, 0);
        tv[12] = mk(0, 32'h0,         4'hF, 8'd4, 1, 0, 5'd2, 0, 32'hB000_0001, 4'hC, 0, 0, 0);
        tv[13] = mk(0, 32'h0,         4'hF, 8'd4, 1, 0, 5'd1, 0, 32'hB000_0002, 4'h0, 0, 0, 0);
        tv[14] = mk(0, 32'h0,         4'hF, 8'd4, 1, 1, 5'd0, 0, 32'h0,         4'hF, 1, 1, 0);
        tv[15] = mk(0, 32'h0,         4'hF, 8'd4, 0, 0, 5'd0, 0, 32'h0,         4'hF, 0, 1, 0);
        tv[16] = mk(0, 32'h0,         4'hF, 8'd4, 1, 0, 5'd0, 0, 32'h0,         4'hF, 0, 1, 1);
        tv[17] = mk(0, 32'h0,         4'hF, 8'd4, 0, 0, 5'd0, 0, 32'h0,         4'hF, 0, 1, 1);
        tv[18] = mk(1, 32'hC000_0000, 4'h5, 8'd1, 0, 0, 5'd1, 0, 32'hC000_0000, 4'h5, 0, 1, 1);
        tv[19] = mk(0, 32'h0,         4'hF, 8'd1, 0, 0, 5'd1, 1, 32'hC000_0000, 4'h5, 0, 1, 1);
        tv[20] = mk(0, 32'h0,         4'hF, 8'd1, 0, 1, 5'd0, 0, 32'h0,         4'hF, 1, 1, 1);

        for (int i = 0; i < 21; i++) begin
            string tg;
            tg = $sformatf("vec%0d", i);
            bus.burst_len = tv[i].bl;
            drive(tv[i].wv, tv[i].wd, tv[i].we, tv[i].nx, tv[i].ls, 1'b0);
            tick();
            chk({tg, "_level"},    64'(bus.level), 64'(tv[i].x_lvl));
            chk({tg, "_wr_ready"}, 64'(bus.wr_ready), 64'(tv[i].x_lvl != 5'd16));
            chk({tg, "_bready"},   64'(bus.burst_ready), 64'(tv[i].x_rdy));
            chk({tg, "_data"},     64'(bus.app_wr_data), 64'(tv[i].x_data));
            chk({tg, "_en_n"},     64'(bus.app_wr_en_n), 64'(tv[i].x_en));
            chk({tg, "_bdone"},    64'(bus.burst_done), 64'(tv[i].x_bd));
            chk({tg, "_len_err"},  64'(bus.len_err), 64'(tv[i].x_le));
            chk({tg, "_underrun"}, 64'(bus.underrun_err), 64'(tv[i].x_ur));
        end

        // Reset in the middle of a transfer, with push/pop requests active.
        bus.burst_len = 8'd2;
        drive(1'b1, 32'hD1D1_0000, 4'h0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'hD1D1_0001, 4'h0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0,         4'hF, 1'b1, 1'b0, 1'b0); tick();
        chk("mid_level_before", 64'(bus.level), 64'd1);
        drive(1'b1, 32'hD1D1_0002, 4'h0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, '0, 4'hF, 1'b0, 1'b0, 1'b0);
        check_reset_vals("rst_mid");

        // Fill to full, blocked push, pop frees a slot, wrap of both pointers.
        bus.burst_len = 8'd17;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'hD000_0000 + 32'(i), 4'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("full_level", 64'(bus.level), 64'd16);
        chk("full_wr_ready", 64'(bus.wr_ready), 64'd0);
        drive(1'b1, 32'hE170_0017, 4'h9, 1'b0, 1'b0, 1'b0);
        tick();
        chk("full_hold_level", 64'(bus.level), 64'd16);
        chk("full_hold_head", 64'(bus.app_wr_data), 64'hD000_0000);
        drive(1'b1, 32'hE170_0017, 4'h9, 1'b1, 1'b0, 1'b0);
        tick();
        chk("full_pop_level", 64'(bus.level), 64'd15);
        chk("full_pop_wr_ready", 64'(bus.wr_ready), 64'd1);
        drive(1'b1, 32'hE170_0017, 4'h9, 1'b0, 1'b0, 1'b0);
        tick();
        chk("full_refill_level", 64'(bus.level), 64'd16);
        for (int i = 0; i < 15; i++) lst_w[i] = {4'(i + 1), 32'hD000_0001 + 32'(i)};
        lst_w[15] = {4'h9, 32'hE170_0017};
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("wrap_head%0d", i), 64'({bus.app_wr_en_n, bus.app_wr_data}), 64'(lst_w[i]));
            drive(1'b0, '0, 4'hF, 1'b1, (i == 15), 1'b0);
            tick();
        end
        chk("wrap_level_end", 64'(bus.level), 64'd0);
        chk("wrap_bdone", 64'(bus.burst_done), 64'd1);
        chk("wrap_len_err", 64'(bus.len_err), 64'd0);

        // Steady push+pop at level 2.
        bus.burst_len = 8'd0;
        drive(1'b1, 32'hE000_0000, 4'h0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'hE000_0001, 4'h1, 1'b0, 1'b0, 1'b0); tick();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'hE000_0002 + 32'(k), 4'(k + 2), 1'b1, 1'b0, 1'b0);
            tick();
            chk($sformatf("stream%0d_level", k), 64'(bus.level), 64'd2);
            chk($sformatf("stream%0d_head", k), 64'(bus.app_wr_data), 64'(32'hE000_0001 + 32'(k)));
        end

        // Flush mid-transfer at level 5, colliding with a push and a pop.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'hF000_0000 + 32'(k), 4'h0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("flush_pre_level", 64'(bus.level), 64'd5);
        drive(1'b1, 32'hF0F0_F0F0, 4'h0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, 4'hF, 1'b0, 1'b0, 1'b0);
        chk("flush_level", 64'(bus.level), 64'd0);
        chk("flush_en_n", 64'(bus.app_wr_en_n), 64'hF);
        chk("flush_data", 64'(bus.app_wr_data), 64'd0);
        chk("flush_bdone", 64'(bus.burst_done), 64'd0);
        bus.burst_len = 8'd1;
        drive(1'b1, 32'h6060_0000, 4'h2, 1'b0, 1'b0, 1'b0); tick();
        chk("flush_idle_bready", 64'(bus.burst_ready), 64'd0);
        drive(1'b0, '0, 4'hF, 1'b0, 1'b0, 1'b0); tick();
        chk("flush_armed_bready", 64'(bus.burst_ready), 64'd1);
        drive(1'b0, '0, 4'hF, 1'b1, 1'b1, 1'b0); tick();
        chk("flush_single_bdone", 64'(bus.burst_done), 64'd1);
        chk("flush_single_len_err", 64'(bus.len_err), 64'd0);

        // Randomized bursts against a queue model.
        do_reset();
        begin
            int   phase, len, sent, planned, waitcnt;
            logic exp_lerr, stop;
            phase = 0; sent = 0; planned = 0; waitcnt = 0;
            exp_lerr = 1'b0; stop = 1'b0;
            mq.delete();
            len = $urandom_range(1, 6);
            bus.burst_len = 8'(len);
            for (int c = 0; c < 800 && !stop; c++) begin
                int unsigned sz;
                logic        psh, pp, ls, exp_done;
                logic [31:0] d;
                logic [3:0]  e;
                logic [35:0] hd;
                sz  = mq.size();
                psh = ($urandom_range(0, 2) != 0);
                d   = $urandom;
                e   = 4'($urandom_range(0, 15));
                pp  = (phase == 1) && (sz > 0) && ($urandom_range(0, 3) != 0);
                ls  = pp && (sent + 1 == planned);
                drive(psh, d, e, pp, ls, 1'b0);
                tick();
                if (pp) void'(mq.pop_front());
                if (psh && sz != DEPTH) mq.push_back({e, d});
                exp_done = 1'b0;
                if (pp) begin
                    sent++;
                    if (ls) begin
                        exp_done = 1'b1;
                        if (sent != len) exp_lerr = 1'b1;
                        phase = 0;
                        waitcnt = 0;
                        len = $urandom_range(1, 6);
                    end
                end
                hd = (mq.size() > 0) ? mq[0] : {4'hF, 32'h0};
                chk("rnd_level",    64'(bus.level), 64'(mq.size()));
                chk("rnd_wr_ready", 64'(bus.wr_ready), 64'(mq.size() != DEPTH));
                chk("rnd_head",     64'({bus.app_wr_en_n, bus.app_wr_data}), 64'(hd));
                chk("rnd_bdone",    64'(bus.burst_done), 64'(exp_done));
                chk("rnd_len_err",  64'(bus.len_err), 64'(exp_lerr));
                chk("rnd_underrun", 64'(bus.underrun_err), 64'd0);
                if (phase == 1 && sent > 0)
                    chk("rnd_bready_xfer", 64'(bus.burst_ready), 64'd0);
                if (exp_done) bus.burst_len = 8'(len);
                if (phase == 0 && !exp_done) begin
                    if (bus.burst_ready) begin
                        chk("rnd_bready_level", 64'(mq.size() >= len), 64'd1);
                        phase = 1;
                        sent = 0;
                        case ($urandom_range(0, 4))
                            0: planned = (len > 1) ? len - 1 : len;
                            1: planned = len + 1;
                            default: planned = len;
                        endcase
                    end else begin
                        waitcnt++;
                        if (waitcnt > 80) begin
                            n_chk++;
                            n_err++;
                            $display("FAIL rnd_bready_timeout: got 0 expected 1 within 80 cycles");
                            stop = 1'b1;
                        end
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
